// File: rtl/pprca_rr_sched_pkg.sv
// Shared constants and types for the two-requester round-robin adder scheduler.
// The tag struct tracks ownership of each adder pipeline slot.
package pprca_rr_sched_pkg;

    localparam int PPRCA_LAT = 4;
    localparam int PPRCA_W   = 4;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/pprca_rr_sched_if.sv
// Request/response bundle between the two clients and the scheduler.
// Clients use the master modport, the scheduler uses slave.
interface pprca_rr_sched_if;
    import pprca_rr_sched_pkg::*;

    logic               req0_valid;
    logic               req0_ready;
    logic [PPRCA_W-1:0] req0_a;
    logic [PPRCA_W-1:0] req0_b;
    logic               req0_cin;

    logic               req1_valid;
    logic               req1_ready;
    logic [PPRCA_W-1:0] req1_a;
    logic [PPRCA_W-1:0] req1_b;
    logic               req1_cin;

    logic               rsp0_valid;
    logic [PPRCA_W-1:0] rsp0_sum;
    logic               rsp0_cout;

    logic               rsp1_valid;
    logic [PPRCA_W-1:0] rsp1_sum;
    logic               rsp1_cout;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_sum, rsp0_cout,
        input  rsp1_valid, rsp1_sum, rsp1_cout
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_sum, rsp0_cout,
        output rsp1_valid, rsp1_sum, rsp1_cout
    );

endinterface

// File: rtl/pprca_4bit.sv
// 4-bit pipelined ripple-carry adder: one bit resolved per stage, 4-cycle latency.
// No reset and no stall; results are only meaningful when tracked externally.
module pprca_4bit (
    input  logic       clk,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    function automatic logic [1:0] fa(input logic x, input logic y, input logic c);
        return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

    logic       s1_d, s1_q, c1_d, c1_q;
    logic [2:0] a1_d, a1_q, b1_d, b1_q;
    logic [1:0] s2_d, s2_q, a2_d, a2_q, b2_d, b2_q;
    logic       c2_d, c2_q;
    logic [2:0] s3_d, s3_q;
    logic       c3_d, c3_q, a3_d, a3_q, b3_d, b3_q;
    logic [3:0] s4_d, s4_q;
    logic       c4_d, c4_q;

    // Unconsumed operand bits ride along with the partial sum.
    always_comb begin
        {c1_d, s1_d}    = fa(A[0], B[0], Cin);
        a1_d            = A[3:1];
        b1_d            = B[3:1];

        {c2_d, s2_d[1]} = fa(a1_q[0], b1_q[0], c1_q);
        s2_d[0]         = s1_q;
        a2_d            = a1_q[2:1];
        b2_d            = b1_q[2:1];

        {c3_d, s3_d[2]} = fa(a2_q[0], b2_q[0], c2_q);
        s3_d[1:0]       = s2_q;
        a3_d            = a2_q[1];
        b3_d            = b2_q[1];

        {c4_d, s4_d[3]} = fa(a3_q, b3_q, c3_q);
        s4_d[2:0]       = s3_q;
    end

    always_ff @(posedge clk) begin
        s1_q <= s1_d;  c1_q <= c1_d;  a1_q <= a1_d;  b1_q <= b1_d;
        s2_q <= s2_d;  c2_q <= c2_d;  a2_q <= a2_d;  b2_q <= b2_d;
        s3_q <= s3_d;  c3_q <= c3_d;  a3_q <= a3_d;  b3_q <= b3_d;
        s4_q <= s4_d;  c4_q <= c4_d;
    end

    assign S    = s4_q;
    assign Cout = c4_q;

endmodule

// File: rtl/pprca_rr_sched.sv
// Round-robin scheduler sharing one pipelined adder between two requesters,
// with per-slot ownership tags and per-requester outstanding credit limits.
module pprca_rr_sched
    import pprca_rr_sched_pkg::*;
#(
    parameter int LAT     = PPRCA_LAT,
    parameter int MAX_OUT = 4
) (
    input  logic            clk,
    input  logic            rst,
    pprca_rr_sched_if.slave bus,
    output logic            busy
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

    logic               elig0, elig1, grant;
    req_id_t            gid;
    req_id_t            ptr_q, ptr_d;
    tag_t [LAT-1:0]     tag_q, tag_d;
    logic [2:0]         out0_q, out0_d, out1_q, out1_d;
    logic               rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [PPRCA_W-1:0] rsp0_sum_q, rsp0_sum_d, rsp1_sum_q, rsp1_sum_d;
    logic               rsp0_cout_q, rsp0_cout_d, rsp1_cout_q, rsp1_cout_d;
    logic [PPRCA_W-1:0] add_a, add_b, add_s;
    logic               add_cin, add_cout;
    logic               tag_busy;

    // Pointer only matters on contention; a lone eligible requester always wins.
    always_comb begin
        elig0          = bus.req0_valid && (out0_q < MAX_CNT);
        elig1          = bus.req1_valid && (out1_q < MAX_CNT);
        grant          = elig0 || elig1;
        gid            = elig1 && (!elig0 || ptr_q);
        ptr_d          = grant ? ~gid : ptr_q;
        bus.req0_ready = grant && !gid;
        bus.req1_ready = grant && gid;

        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (grant) begin
            if (gid) begin
                add_a   = bus.req1_a;
                add_b   = bus.req1_b;
                add_cin = bus.req1_cin;
            end else begin
                add_a   = bus.req0_a;
                add_b   = bus.req0_b;
                add_cin = bus.req0_cin;
            end
        end
    end

    always_comb begin
        tag_d[0].valid = grant;
        tag_d[0].id    = gid;
        for (int i = 1; i < LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // The last tag stage lines up with the adder output in the same cycle.
    always_comb begin
        rsp0_valid_d = 1'b0;
        rsp0_sum_d   = rsp0_sum_q;
        rsp0_cout_d  = rsp0_cout_q;
        rsp1_valid_d = 1'b0;
        rsp1_sum_d   = rsp1_sum_q;
        rsp1_cout_d  = rsp1_cout_q;
        if (tag_q[LAT-1].valid) begin
            if (tag_q[LAT-1].id) begin
                rsp1_valid_d = 1'b1;
                rsp1_sum_d   = add_s;
                rsp1_cout_d  = add_cout;
            end else begin
                rsp0_valid_d = 1'b1;
                rsp0_sum_d   = add_s;
                rsp0_cout_d  = add_cout;
            end
        end
    end

    always_comb begin
        out0_d = out0_q + 3'(bus.req0_ready) - 3'(rsp0_valid_q);
        out1_d = out1_q + 3'(bus.req1_ready) - 3'(rsp1_valid_q);
    end

    always_comb begin
        tag_busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            tag_busy = tag_busy | tag_q[i].valid;
        end
        busy = tag_busy || rsp0_valid_q || rsp1_valid_q ||
               (out0_q != 3'd0) || (out1_q != 3'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= 1'b0;
            tag_q        <= '0;
            out0_q       <= '0;
            out1_q       <= '0;
            rsp0_valid_q <= 1'b0;
            rsp0_sum_q   <= '0;
            rsp0_cout_q  <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_sum_q   <= '0;
            rsp1_cout_q  <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            tag_q        <= tag_d;
            out0_q       <= out0_d;
            out1_q       <= out1_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_sum_q   <= rsp0_sum_d;
            rsp0_cout_q  <= rsp0_cout_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_sum_q   <= rsp1_sum_d;
            rsp1_cout_q  <= rsp1_cout_d;
        end
    end

    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp0_sum   = rsp0_sum_q;
    assign bus.rsp0_cout  = rsp0_cout_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp1_sum   = rsp1_sum_q;
    assign bus.rsp1_cout  = rsp1_cout_q;

    pprca_4bit u_add (
        .clk  (clk),
        .A    (add_a),
        .B    (add_b),
        .Cin  (add_cin),
        .S    (add_s),
        .Cout (add_cout)
    );

endmodule

// File: tb/tb_pprca_rr_sched.sv
// Directed bench: a per-cycle vector table on one instance, plus hand-written
// credit-limit, mid-flight reset and idle-pointer sequences on a MAX_OUT=2 instance.
module tb_pprca_rr_sched;

    logic clk;
    logic rst_t, rst_c;
    logic busy_t, busy_c;
    int   n_chk  = 0;
    int   n_fail = 0;

    pprca_rr_sched_if bus_t ();
    pprca_rr_sched_if bus_c ();

    // Six back-to-back issues from one requester need six credits.
    pprca_rr_sched #(.MAX_OUT(6)) dut_t (
        .clk  (clk),
        .rst  (rst_t),
        .bus  (bus_t),
        .busy (busy_t)
    );

    pprca_rr_sched #(.MAX_OUT(2)) dut_c (
        .clk  (clk),
        .rst  (rst_c),
        .bus  (bus_c),
        .busy (busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, chk;
        logic       v0;  logic [3:0] a0, b0;  logic c0;
        logic       v1;  logic [3:0] a1, b1;  logic c1;
        logic       r0, r1;
        logic       rv0; logic [3:0] rs0;     logic rc0;
        logic       rv1; logic [3:0] rs1;     logic rc1;
        logic       bsy;
    } vec_t;

    vec_t tbl[$];
    vec_t v;

    function automatic vec_t mk(int rst, int v0, int a0, int b0, int c0,
                                int v1, int a1, int b1, int c1, int r0, int r1,
                                int rv0, int rs0, int rc0, int rv1, int rs1, int rc1,
                                int bsy);
        vec_t x;
        x.rst = 1'(rst);  x.chk = !1'(rst);
        x.v0  = 1'(v0);   x.a0  = 4'(a0);  x.b0 = 4'(b0);  x.c0 = 1'(c0);
        x.v1  = 1'(v1);   x.a1  = 4'(a1);  x.b1 = 4'(b1);  x.c1 = 1'(c1);
        x.r0  = 1'(r0);   x.r1  = 1'(r1);
        x.rv0 = 1'(rv0);  x.rs0 = 4'(rs0); x.rc0 = 1'(rc0);
        x.rv1 = 1'(rv1);  x.rs1 = 4'(rs1); x.rc1 = 1'(rc1);
        x.bsy = 1'(bsy);
        return x;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_c(int v0, int a0, int b0, int c0, int v1, int a1, int b1, int c1);
        bus_c.req0_valid = 1'(v0); bus_c.req0_a = 4'(a0); bus_c.req0_b = 4'(b0); bus_c.req0_cin = 1'(c0);
        bus_c.req1_valid = 1'(v1); bus_c.req1_a = 4'(a1); bus_c.req1_b = 4'(b1); bus_c.req1_cin = 1'(c1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] rdy_mask;
        logic [13:0] rsp_mask;

        // Single op: C+D+0 = 0x19 -> sum 9, cout 1 in cycle 5.
        tbl.push_back(mk(0, 1,'hC,'hD,0, 0,0,0,0, 1,0, 0,0,0, 0,0,0, 0));
        repeat (4) tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0, 1));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 1,9,1, 0,0,0, 1));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,9,1, 0,0,0, 0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0, 0));
        // Contention: 8+1+0 = 9; 2+D+1 = 0x10.
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 1,8,1,0, 1,2,'hD,1, (k%2==0),(k%2==1), 0,0,0, 0,0,0, (k>0)));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0, 1));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 1,9,0, 0,0,0, 1));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,9,0, 1,0,1, 1));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 1,9,0, 0,0,1, 1));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,9,0, 1,0,1, 1));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,9,0, 0,0,1, 0));
        // Back-to-back req1: 4+7+0 = 0xB.
        tbl.push_back(mk(0, 0,0,0,0, 1,4,7,0, 0,1, 0,9,0, 0,0,1, 0));
        repeat (4) tbl.push_back(mk(0, 0,0,0,0, 1,4,7,0, 0,1, 0,9,0, 0,0,1, 1));
        tbl.push_back(mk(0, 0,0,0,0, 1,4,7,0, 0,1, 0,9,0, 1,'hB,0, 1));
        repeat (5) tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,9,0, 1,'hB,0, 1));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,9,0, 0,'hB,0, 0));

        rst_t = 1'b1; rst_c = 1'b1;
        bus_t.req0_valid = 1'b0; bus_t.req0_a = '0; bus_t.req0_b = '0; bus_t.req0_cin = 1'b0;
        bus_t.req1_valid = 1'b0; bus_t.req1_a = '0; bus_t.req1_b = '0; bus_t.req1_cin = 1'b0;
        drive_c(0,0,0,0, 0,0,0,0);
        tick();
        tick();
        rst_t = 1'b0; rst_c = 1'b0;

        check("reset busy_c", 8'(busy_c), 8'd0);
        check("reset rsp0_valid_c", 8'(bus_c.rsp0_valid), 8'd0);
        check("reset rsp1 sum_c", 8'({bus_c.rsp1_cout, bus_c.rsp1_sum}), 8'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            rst_t = v.rst;
            bus_t.req0_valid = v.v0; bus_t.req0_a = v.a0; bus_t.req0_b = v.b0; bus_t.req0_cin = v.c0;
            bus_t.req1_valid = v.v1; bus_t.req1_a = v.a1; bus_t.req1_b = v.b1; bus_t.req1_cin = v.c1;
            #1;
            if (v.chk) begin
                check($sformatf("row%0d req0_ready", i), 8'(bus_t.req0_ready), 8'(v.r0));
                check($sformatf("row%0d req1_ready", i), 8'(bus_t.req1_ready), 8'(v.r1));
                check($sformatf("row%0d rsp0_valid", i), 8'(bus_t.rsp0_valid), 8'(v.rv0));
                check($sformatf("row%0d rsp0_sum", i),   8'(bus_t.rsp0_sum),   8'(v.rs0));
                check($sformatf("row%0d rsp0_cout", i),  8'(bus_t.rsp0_cout),  8'(v.rc0));
                check($sformatf("row%0d rsp1_valid", i), 8'(bus_t.rsp1_valid), 8'(v.rv1));
                check($sformatf("row%0d rsp1_sum", i),   8'(bus_t.rsp1_sum),   8'(v.rs1));
                check($sformatf("row%0d rsp1_cout", i),  8'(bus_t.rsp1_cout),  8'(v.rc1));
                check($sformatf("row%0d busy", i),       8'(busy_t),           8'(v.bsy));
            end
            tick();
        end
        rst_t = 1'b0;

        // Credit limit 2 with req0 held valid: 3+4+1 = 8.
        rdy_mask = 14'b11000011000011;
        rsp_mask = 14'b01100001100000;
        for (int cyc = 0; cyc < 14; cyc++) begin
            drive_c(1,3,4,1, 0,0,0,0);
            #1;
            check($sformatf("credit c%0d req0_ready", cyc), 8'(bus_c.req0_ready), 8'(rdy_mask[cyc]));
            check($sformatf("credit c%0d rsp0_valid", cyc), 8'(bus_c.rsp0_valid), 8'(rsp_mask[cyc]));
            if (rsp_mask[cyc])
                check($sformatf("credit c%0d rsp0", cyc), 8'({bus_c.rsp0_cout, bus_c.rsp0_sum}), 8'h08);
            tick();
        end
        drive_c(0,0,0,0, 0,0,0,0);
        repeat (8) tick();
        check("credit drained busy", 8'(busy_c), 8'd0);

        // Reset two cycles after accepting 5+5+1; that op must never respond.
        drive_c(1,5,5,1, 0,0,0,0);
        #1;
        check("rst c0 req0_ready", 8'(bus_c.req0_ready), 8'd1);
        tick();
        drive_c(0,0,0,0, 0,0,0,0);
        tick();
        rst_c = 1'b1;
        tick();
        rst_c = 1'b0;
        for (int cyc = 3; cyc < 12; cyc++) begin
            if (cyc == 3)      drive_c(1,1,2,0, 0,0,0,0);
            else if (cyc == 4) drive_c(0,0,0,0, 1,2,2,0);
            else               drive_c(0,0,0,0, 0,0,0,0);
            #1;
            check($sformatf("rst c%0d req0_ready", cyc), 8'(bus_c.req0_ready), 8'(cyc == 3));
            check($sformatf("rst c%0d req1_ready", cyc), 8'(bus_c.req1_ready), 8'(cyc == 4));
            check($sformatf("rst c%0d rsp0_valid", cyc), 8'(bus_c.rsp0_valid), 8'(cyc == 8));
            check($sformatf("rst c%0d rsp1_valid", cyc), 8'(bus_c.rsp1_valid), 8'(cyc == 9));
            if (cyc == 3) begin
                check("rst c3 busy", 8'(busy_c), 8'd0);
                check("rst c3 rsp0 cleared", 8'({bus_c.rsp0_cout, bus_c.rsp0_sum}), 8'h00);
            end
            if (cyc == 8)  check("rst c8 rsp0", 8'({bus_c.rsp0_cout, bus_c.rsp0_sum}), 8'h03);
            if (cyc == 9)  check("rst c9 rsp1", 8'({bus_c.rsp1_cout, bus_c.rsp1_sum}), 8'h04);
            if (cyc == 11) check("rst c11 busy", 8'(busy_c), 8'd0);
            tick();
        end

        // Pointer holds across idle cycles.
        drive_c(1,1,1,0, 0,0,0,0);
        #1;
        check("ptr p0 req0_ready", 8'(bus_c.req0_ready), 8'd1);
        tick();
        drive_c(0,0,0,0, 1,1,1,0);
        #1;
        check("ptr p1 req1_ready", 8'(bus_c.req1_ready), 8'd1);
        tick();
        drive_c(0,0,0,0, 0,0,0,0);
        repeat (3) tick();
        drive_c(1,1,1,0, 1,1,1,0);
        #1;
        check("ptr p5 req0_ready", 8'(bus_c.req0_ready), 8'd1);
        check("ptr p5 req1_ready", 8'(bus_c.req1_ready), 8'd0);
        tick();
        #1;
        check("ptr p6 req0_ready", 8'(bus_c.req0_ready), 8'd0);
        check("ptr p6 req1_ready", 8'(bus_c.req1_ready), 8'd1);
        tick();
        drive_c(0,0,0,0, 0,0,0,0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
